store_buffer: RTL and testbench
===============================

# store_buffer

Post-commit store buffer between the reorder buffer's memory-write head port and the dCache write port. Each store retired by the ROB is pushed into a small in-order FIFO and drained to the dCache through a request/acknowledge handshake. The ROB can therefore retire a store in one cycle even when the cache is busy. Loads probe the buffer for the youngest pending store to the same word so the load unit can forward committed-but-undrained data.

## Interface
- ARCH_BITS, 32: address/data width
- SB_SLOTS, 4: number of buffer entries, power of two
- SB_IDX_BITS, 2: log2(SB_SLOTS)
- BYTE_IDX_BITS, 2: byte-offset bits ignored in word match
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-low; entries invalidated when rst==0 at a rising edge
- wEnableMem  in  1  push request from the ROB head (a store retires this cycle)
- wAddressMem  in  ARCH_BITS  store address
- wDataMem  in  ARCH_BITS  store data; for byte stores only bits [7:0] are meaningful
- wByteMem  in  1  1 = byte store, 0 = word store
- full  out  1  buffer holds SB_SLOTS entries; the ROB must not retire a store while full unless memAck is high
- empty  out  1  buffer holds no entries
- overflow  out  1  sticky; a push was dropped
- memReq  out  1  drain request to the dCache
- memAddr  out  ARCH_BITS  oldest entry address
- memData  out  ARCH_BITS  oldest entry data
- memByte  out  1  oldest entry byte flag
- memAck  in  1  dCache accepts the current request this cycle
- fwdAddr  in  ARCH_BITS  load address to probe
- fwdHit  out  1  a pending store matches fwdAddr on bits [ARCH_BITS-1:BYTE_IDX_BITS]
- fwdData  out  ARCH_BITS  data of the youngest matching store
- fwdByte  out  1  byte flag of the youngest matching store
- fwdAddrOut  out  ARCH_BITS  full address of the youngest matching store

## Operation
- State:
  - circular arrays of address, data, byte flag and valid per slot
  - head pointer and tail pointer, each SB_IDX_BITS wide, wrapping modulo SB_SLOTS
  - count, SB_IDX_BITS+1 wide
- Push: accepted when wEnableMem && (!full || memAck). The entry is written at the tail, the tail increments and the slot becomes valid.
- Dropped push: wEnableMem && full && !memAck. The entry is discarded, state is unchanged and overflow is set. overflow clears only on reset.
- Pop: occurs when memReq && memAck. The head slot is invalidated and the head increments.
- Count update:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged
- Flags: full = (count == SB_SLOTS), empty = (count == 0), memReq = !empty.
- Drain fields: memAddr, memData and memByte always reflect the head slot. They are held stable while memReq is high and memAck is low.
- memAck while memReq is low is ignored.
- The buffer is never flushed by pipeline clears; committed stores always drain.
- Forwarding search:
  - Scans the valid entries oldest to youngest and keeps the last match, so the youngest store wins.
  - The same-cycle push, when accepted, is also searched and is treated as the youngest entry.
  - An entry popping this cycle still participates in the search.
- With no hit, fwdData, fwdByte and fwdAddrOut are don't-care and fwdHit = 0.

## Timing
- Reset values (after a rising edge with rst==0):
  - head = tail = count = 0, all slots invalid
  - full = 0, empty = 1, overflow = 0, memReq = 0, fwdHit = 0
- Reset mid-drain: any outstanding request is abandoned. memReq drops in the cycle after the reset edge, and the dCache must discard it.
- Push to memReq latency: 1 cycle. A store pushed at edge N is presented on memReq after edge N.
- memReq, memAddr, memData, memByte, full, empty and overflow are registered-state outputs with no combinational input dependence.
- Forward outputs are combinational from fwdAddr, the registered entries and the current push inputs (wEnableMem, wAddressMem, wDataMem, wByteMem).
- Throughput: one push and one pop per cycle sustained.
- When full, a push accompanied by memAck in the same cycle is accepted.
- Pointer wrap: the pointer value after SB_SLOTS-1 is 0.

## Configuration
- Macro: STORE_BUFFER_FWD_EN.
- Defined: the forwarding search logic is compiled in, as described above.
- Undefined:
  - the search logic is omitted
  - fwdHit is tied to 0; fwdData, fwdAddrOut and fwdByte are tied to 0
  - fwdAddr is unused
  - all other behaviour is identical

## Test plan
- Reset then idle: hold rst=0 for 2 cycles, then release -> empty=1, memReq=0, full=0, overflow=0.
- Single store: push addr 0x100, data 0xDEADBEEF, word; hold memAck=0 for 3 cycles -> memReq=1 with memAddr 0x100 and memData 0xDEADBEEF held stable; assert memAck -> empty=1 on the next cycle.
- Fill and overflow: with memAck=0, push 4 stores -> full=1. Push a 5th -> dropped, overflow=1, count stays 4. Then push with memAck=1 -> accepted, count stays 4, head advances.
- Youngest-match forwarding (STORE_BUFFER_FWD_EN defined):
  - push 0x200/0x11111111 word, then 0x202/0x000000AA byte
  - probe fwdAddr 0x201 -> fwdHit=1, fwdData=0x000000AA, fwdByte=1, fwdAddrOut=0x202
  - probe 0x204 -> fwdHit=0
- Same-cycle push forwarding: while pushing 0x300/0x55 word, probe fwdAddr 0x300 in the same cycle -> fwdHit=1, fwdData=0x55.
- Wrap-around and reset mid-operation: push/pop 10 stores with memAck=1 so the pointers wrap and drain order matches push order; then with 2 entries pending, assert rst=0 for one edge -> empty=1, memReq=0, and no further requests issue.

Source files
------------

// File: rtl/store_buffer_if.sv
// Store buffer bus: ROB push port, dCache drain port and load-forward probe.
interface store_buffer_if #(
  parameter int ARCH_BITS = 32
);
  logic                 wEnableMem;
  logic [ARCH_BITS-1:0] wAddressMem;
  logic [ARCH_BITS-1:0] wDataMem;
  logic                 wByteMem;
  logic                 full;
  logic                 empty;
  logic                 overflow;
  logic                 memReq;
  logic [ARCH_BITS-1:0] memAddr;
  logic [ARCH_BITS-1:0] memData;
  logic                 memByte;
  logic                 memAck;
  logic [ARCH_BITS-1:0] fwdAddr;
  logic                 fwdHit;
  logic [ARCH_BITS-1:0] fwdData;
  logic                 fwdByte;
  logic [ARCH_BITS-1:0] fwdAddrOut;

  modport master (
    output wEnableMem, wAddressMem, wDataMem, wByteMem, memAck, fwdAddr,
    input  full, empty, overflow, memReq, memAddr, memData, memByte,
    input  fwdHit, fwdData, fwdByte, fwdAddrOut
  );

  modport slave (
    input  wEnableMem, wAddressMem, wDataMem, wByteMem, memAck, fwdAddr,
    output full, empty, overflow, memReq, memAddr, memData, memByte,
    output fwdHit, fwdData, fwdByte, fwdAddrOut
  );
endinterface

// File: rtl/store_buffer.sv
// Post-commit in-order store buffer draining to the dCache; load forwarding
// search is compiled in only when STORE_BUFFER_FWD_EN is defined.
module store_buffer #(
  parameter int ARCH_BITS     = 32,
  parameter int SB_SLOTS      = 4,
  parameter int SB_IDX_BITS   = 2,
  parameter int BYTE_IDX_BITS = 2
) (
  input  logic           clk,
  input  logic           rst,
  store_buffer_if.slave  bus
);
  localparam logic [SB_IDX_BITS-1:0] IDX_ONE  = 1;
  localparam logic [SB_IDX_BITS:0]   CNT_ONE  = 1;
  localparam logic [SB_IDX_BITS:0]   CNT_FULL = (SB_IDX_BITS+1)'(SB_SLOTS);

  logic [ARCH_BITS-1:0]   addr_q [SB_SLOTS];
  logic [ARCH_BITS-1:0]   data_q [SB_SLOTS];
  logic [SB_SLOTS-1:0]    byte_q;
  logic [SB_SLOTS-1:0]    valid_q;
  logic [SB_IDX_BITS-1:0] head;
  logic [SB_IDX_BITS-1:0] tail;
  logic [SB_IDX_BITS:0]   count;
  logic                   overflow_q;
  logic                   is_full;
  logic                   is_empty;
  logic                   push;
  logic                   pop;
  logic                   drop;

  assign is_full  = (count == CNT_FULL);
  assign is_empty = (count == '0);
  // A full buffer still accepts a push when the head drains in the same cycle.
  assign push = bus.wEnableMem && (!is_full || bus.memAck);
  assign drop = bus.wEnableMem && is_full && !bus.memAck;
  assign pop  = !is_empty && bus.memAck;

  always_ff @(posedge clk) begin
    if (!rst) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      valid_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (pop) begin
        valid_q[head] <= 1'b0;
        head          <= head + IDX_ONE;
      end
      if (push) begin
        valid_q[tail] <= 1'b1;
        tail          <= tail + IDX_ONE;
      end
      if (push && !pop) begin
        count <= count + CNT_ONE;
      end else if (pop && !push) begin
        count <= count - CNT_ONE;
      end
      if (drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail] <= bus.wAddressMem;
      data_q[tail] <= bus.wDataMem;
      byte_q[tail] <= bus.wByteMem;
    end
  end

  assign bus.full     = is_full;
  assign bus.empty    = is_empty;
  assign bus.overflow = overflow_q;
  assign bus.memReq   = !is_empty;
  assign bus.memAddr  = addr_q[head];
  assign bus.memData  = data_q[head];
  assign bus.memByte  = byte_q[head];

`ifdef STORE_BUFFER_FWD_EN
  logic [SB_IDX_BITS-1:0] scan_idx;
  logic                   fwd_hit;
  logic [ARCH_BITS-1:0]   fwd_data;
  logic                   fwd_byte;
  logic [ARCH_BITS-1:0]   fwd_addr;
  logic                   unused_fwd_lo;

  assign unused_fwd_lo = &{1'b0, bus.fwdAddr[BYTE_IDX_BITS-1:0]};

  // Oldest-to-youngest scan keeps the last match; the accepted push is youngest.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_byte = 1'b0;
    fwd_addr = '0;
    scan_idx = head;
    for (int i = 0; i < SB_SLOTS; i++) begin
      scan_idx = head + SB_IDX_BITS'(i);
      if (valid_q[scan_idx] &&
          addr_q[scan_idx][ARCH_BITS-1:BYTE_IDX_BITS] == bus.fwdAddr[ARCH_BITS-1:BYTE_IDX_BITS]) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[scan_idx];
        fwd_byte = byte_q[scan_idx];
        fwd_addr = addr_q[scan_idx];
      end
    end
    if (push &&
        bus.wAddressMem[ARCH_BITS-1:BYTE_IDX_BITS] == bus.fwdAddr[ARCH_BITS-1:BYTE_IDX_BITS]) begin
      fwd_hit  = 1'b1;
      fwd_data = bus.wDataMem;
      fwd_byte = bus.wByteMem;
      fwd_addr = bus.wAddressMem;
    end
  end

  assign bus.fwdHit     = fwd_hit;
  assign bus.fwdData    = fwd_data;
  assign bus.fwdByte    = fwd_byte;
  assign bus.fwdAddrOut = fwd_addr;
`else
  logic unused_fwd;

  assign unused_fwd     = &{1'b0, bus.fwdAddr, valid_q};
  assign bus.fwdHit     = 1'b0;
  assign bus.fwdData    = '0;
  assign bus.fwdByte    = 1'b0;
  assign bus.fwdAddrOut = '0;
`endif
endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: drains are checked in push order by a
// monitor; flags and forwarding are checked against hand-computed values.
module tb_store_buffer;
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        bf;
  } exp_t;

`ifdef STORE_BUFFER_FWD_EN
  localparam logic FWD_ON = 1'b1;
`else
  localparam logic FWD_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   exp_count = 0;
  logic pend_push = 1'b0;
  logic pend_pop = 1'b0;
  exp_t exp_q[$];

  store_buffer_if #(.ARCH_BITS(32)) bus ();

  store_buffer #(
    .ARCH_BITS(32),
    .SB_SLOTS(4),
    .SB_IDX_BITS(2),
    .BYTE_IDX_BITS(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs and enqueue the drain it should eventually cause.
  task automatic applyStimulus(input logic we, input logic [31:0] addr,
                               input logic [31:0] data, input logic bf,
                               input logic ack);
    exp_t e;
    bus.wEnableMem  = we;
    bus.wAddressMem = addr;
    bus.wDataMem    = data;
    bus.wByteMem    = bf;
    bus.memAck      = ack;
    pend_push = we && (exp_count < 4 || ack);
    pend_pop  = (exp_count > 0) && ack;
    if (pend_push) begin
      e.addr = addr;
      e.data = data;
      e.bf   = bf;
      exp_q.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    exp_count = exp_count + int'(pend_push) - int'(pend_pop);
    pend_push = 1'b0;
    pend_pop  = 1'b0;
    bus.wEnableMem = 1'b0;
    bus.memAck     = 1'b0;
  endtask

  // Every accepted drain must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst && bus.memReq && bus.memAck) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_drain", bus.memAddr, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("drain_addr", bus.memAddr, e.addr);
        checkOutput("drain_data", bus.memData, e.data);
        checkOutput("drain_byte", {31'd0, bus.memByte}, {31'd0, e.bf});
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: actual timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.wEnableMem  = 1'b0;
    bus.wAddressMem = '0;
    bus.wDataMem    = '0;
    bus.wByteMem    = 1'b0;
    bus.memAck      = 1'b0;
    bus.fwdAddr     = '0;

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    checkOutput("reset_empty", {31'd0, bus.empty}, 32'd1);
    checkOutput("reset_memreq", {31'd0, bus.memReq}, 32'd0);
    checkOutput("reset_full", {31'd0, bus.full}, 32'd0);
    checkOutput("reset_overflow", {31'd0, bus.overflow}, 32'd0);
    checkOutput("reset_fwdhit", {31'd0, bus.fwdHit}, 32'd0);

    $display("[TB] single store with delayed ack");
    applyStimulus(1'b1, 32'h100, 32'hDEAD_BEEF, 1'b0, 1'b0);
    tick();
    bus.fwdAddr = 32'h103;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("hold_memreq", {31'd0, bus.memReq}, 32'd1);
      checkOutput("hold_addr", bus.memAddr, 32'h100);
      checkOutput("hold_data", bus.memData, 32'hDEAD_BEEF);
      checkOutput("pending_fwdhit", {31'd0, bus.fwdHit}, {31'd0, FWD_ON});
      tick();
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    tick();
    checkOutput("single_empty", {31'd0, bus.empty}, 32'd1);
    checkOutput("single_memreq", {31'd0, bus.memReq}, 32'd0);

    $display("[TB] fill and overflow");
    for (int i = 0; i < 4; i++) begin
      checkOutput("fill_not_full", {31'd0, bus.full}, 32'd0);
      applyStimulus(1'b1, 32'h400 + 32'(4 * i), 32'hA0 + 32'(i), 1'b0, 1'b0);
      tick();
    end
    checkOutput("fill_full", {31'd0, bus.full}, 32'd1);
    applyStimulus(1'b1, 32'h410, 32'hA4, 1'b0, 1'b0);
    tick();
    checkOutput("drop_overflow", {31'd0, bus.overflow}, 32'd1);
    checkOutput("drop_full", {31'd0, bus.full}, 32'd1);
    checkOutput("drop_head", bus.memAddr, 32'h400);
    applyStimulus(1'b1, 32'h414, 32'hA5, 1'b1, 1'b1);
    tick();
    checkOutput("full_push_ack_full", {31'd0, bus.full}, 32'd1);
    checkOutput("full_push_ack_head", bus.memAddr, 32'h404);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      tick();
    end
    checkOutput("fill_drained", {31'd0, bus.empty}, 32'd1);
    checkOutput("overflow_sticky", {31'd0, bus.overflow}, 32'd1);

    $display("[TB] youngest-match forwarding");
    applyStimulus(1'b1, 32'h200, 32'h1111_1111, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h202, 32'h0000_00AA, 1'b1, 1'b0);
    tick();
    bus.fwdAddr = 32'h201;
    #1;
    checkOutput("young_fwdhit", {31'd0, bus.fwdHit}, {31'd0, FWD_ON});
`ifdef STORE_BUFFER_FWD_EN
    checkOutput("young_fwddata", bus.fwdData, 32'h0000_00AA);
    checkOutput("young_fwdbyte", {31'd0, bus.fwdByte}, 32'd1);
    checkOutput("young_fwdaddr", bus.fwdAddrOut, 32'h202);
`endif
    bus.fwdAddr = 32'h204;
    #1;
    checkOutput("miss_fwdhit", {31'd0, bus.fwdHit}, 32'd0);

    $display("[TB] same-cycle push forwarding");
    applyStimulus(1'b1, 32'h300, 32'h55, 1'b0, 1'b0);
    bus.fwdAddr = 32'h300;
    #1;
    checkOutput("samecyc_fwdhit", {31'd0, bus.fwdHit}, {31'd0, FWD_ON});
`ifdef STORE_BUFFER_FWD_EN
    checkOutput("samecyc_fwddata", bus.fwdData, 32'h55);
    checkOutput("samecyc_fwdaddr", bus.fwdAddrOut, 32'h300);
`endif
    tick();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      tick();
    end
    checkOutput("fwd_drained", {31'd0, bus.empty}, 32'd1);

    $display("[TB] wrap-around streaming");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 32'h500 + 32'(4 * i), 32'hC000 + 32'(i), 1'(i % 2), 1'b1);
      tick();
    end
    checkOutput("wrap_head", bus.memAddr, 32'h524);
    applyStimulus(1'b1, 32'h528, 32'hC00A, 1'b0, 1'b0);
    tick();
    checkOutput("wrap_pending", {31'd0, bus.empty}, 32'd0);

    $display("[TB] reset mid-operation");
    rst = 1'b0;
    tick();
    rst = 1'b1;
    exp_q.delete();
    exp_count = 0;
    checkOutput("midreset_empty", {31'd0, bus.empty}, 32'd1);
    checkOutput("midreset_memreq", {31'd0, bus.memReq}, 32'd0);
    checkOutput("midreset_overflow", {31'd0, bus.overflow}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      tick();
      checkOutput("post_reset_idle", {31'd0, bus.memReq}, 32'd0);
    end

    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
